// File: rtl/win3x3_pkg.sv
// Shared constants and types for the 3x3 window generator.
package win3x3_pkg;

  localparam int TL        = 0;
  localparam int CTR       = 4;
  localparam int BR        = 8;
  localparam int WIN_WORDS = BR + 1;
  localparam int MIN_DIM   = 3;

  typedef struct packed {
    logic sof;
    logic eof;
    logic sol;
    logic eol;
  } win_flags_t;

endpackage

// File: rtl/win3x3_line_ram.sv
// Simple dual-port line RAM with registered read; a same-address read and write return the old word.
module win3x3_line_ram
  import win3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_3x3_1px.sv
// 1 pixel/cycle raster to 3x3 neighbourhood window converter, two line buffers + column shifters.
// Optional WIN3X3_DIM_CHECK_EN adds dim_err: pulses when a line width differs from the frame's first line.
module window_3x3_1px
  import win3x3_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_LINE_WIDTH = 1024,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_sof,
  input  logic                              in_eof,
  input  logic                              in_sol,
  input  logic                              in_eol,
  output logic                              out3x3_val,
  input  logic                              out3x3_rdy,
  output logic [WIN_WORDS*DATA_WIDTH-1:0]   out3x3_data,
  output logic                              out3x3_sof,
  output logic                              out3x3_eof,
  output logic                              out3x3_sol,
  output logic                              out3x3_eol,
`ifdef WIN3X3_DIM_CHECK_EN
  output logic                              dim_err,
`endif
  output logic                              ovf_err
);

  localparam logic [ADDR_WIDTH-1:0] COL_MAX  = ADDR_WIDTH'(MAX_LINE_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_EDGE = ADDR_WIDTH'(MIN_DIM - 1);
  localparam logic [15:0]           ROW_EDGE = 16'(MIN_DIM - 1);
  localparam int                    STAGES   = 2;

  logic                  en, acc, pix_ok, line_start, line_end, ovf_pix, emit;
  logic                  in_frame, col_full;
  logic [ADDR_WIDTH-1:0] col_q, cur_col;
  logic [15:0]           row_q, cur_row;

  logic [STAGES:1]       vld_pipe;
  logic                  s1_wr, s1_emit;
  logic [ADDR_WIDTH-1:0] s1_col;
  logic [DATA_WIDTH-1:0] s1_data, lb0_rdata, lb1_rdata;
  win_flags_t            s1_flags, out_flags;

  logic [BR:TL][DATA_WIDTH-1:0] win;
  logic [2:0][DATA_WIDTH-1:0]   col_new;

  always_comb begin
    en         = ~out3x3_val | out3x3_rdy;
    acc        = in_val & en;
    line_start = in_sof | in_sol;
    line_end   = in_eol | in_eof;
    // pixels after a reset or eof are dropped until the next sof
    pix_ok     = acc & (in_frame | in_sof);
    cur_col    = line_start ? '0 : col_q;
    cur_row    = in_sof ? '0 : row_q;
    ovf_pix    = ~line_start & col_full;
    emit       = (cur_row >= ROW_EDGE) & (cur_col >= COL_EDGE) & ~ovf_pix;
  end

  assign in_rdy = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      col_full <= 1'b0;
      ovf_err  <= 1'b0;
    end else if (pix_ok) begin
      in_frame <= ~in_eof;
      if (line_end) begin
        col_q    <= '0;
        col_full <= 1'b0;
        row_q    <= (cur_row == 16'hFFFF) ? cur_row : cur_row + 16'd1;
      end else begin
        col_q    <= (cur_col == COL_MAX) ? cur_col : cur_col + 1'b1;
        col_full <= (cur_col == COL_MAX);
        row_q    <= cur_row;
      end
      if (ovf_pix)     ovf_err <= 1'b1;
      else if (in_sof) ovf_err <= 1'b0;
    end
  end

  // LB0 takes the new line; LB1 is fed LB0's old word one cycle later, once the read has landed
  win3x3_line_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lb0 (
    .clk(clk), .we(pix_ok & ~ovf_pix), .waddr(cur_col), .wdata(in_data),
    .re(pix_ok), .raddr(cur_col), .rdata(lb0_rdata)
  );

  win3x3_line_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lb1 (
    .clk(clk), .we(en & vld_pipe[1] & s1_wr), .waddr(s1_col), .wdata(lb0_rdata),
    .re(pix_ok), .raddr(cur_col), .rdata(lb1_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst)     vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[1] & s1_emit, pix_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_wr    <= 1'b0;
      s1_emit  <= 1'b0;
      s1_col   <= '0;
      s1_data  <= '0;
      s1_flags <= '0;
    end else if (en) begin
      s1_wr        <= ~ovf_pix;
      s1_emit      <= emit;
      s1_col       <= cur_col;
      s1_data      <= in_data;
      s1_flags.sof <= (cur_row == ROW_EDGE) & (cur_col == COL_EDGE);
      s1_flags.eof <= in_eof;
      s1_flags.sol <= (cur_col == COL_EDGE);
      s1_flags.eol <= line_end;
    end
  end

  assign col_new = {s1_data, lb0_rdata, lb1_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      win       <= '0;
      out_flags <= '0;
    end else if (en) begin
      out_flags <= s1_flags;
      if (vld_pipe[1]) begin
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
          win[3*r+2] <= col_new[r];
        end
      end
    end
  end

  assign out3x3_val  = vld_pipe[STAGES];
  assign out3x3_data = win;
  assign out3x3_sof  = out_flags.sof;
  assign out3x3_eof  = out_flags.eof;
  assign out3x3_sol  = out_flags.sol;
  assign out3x3_eol  = out_flags.eol;

`ifdef WIN3X3_DIM_CHECK_EN
  logic [ADDR_WIDTH-1:0] first_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_w <= '0;
      dim_err <= 1'b0;
    end else begin
      dim_err <= 1'b0;
      if (pix_ok & line_end) begin
        if (cur_row == 16'd0)       first_w <= cur_col;
        else if (cur_col != first_w) dim_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_window_3x3_1px.sv
// Bench for window_3x3_1px: vector table, random frames against a window model, corner sequences.
module tb_window_3x3_1px;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_val = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0, in_eof = 1'b0, in_sol = 1'b0, in_eol = 1'b0;
  logic        out_rdy = 1'b1;
  logic        s_rdy = 1'b1;

  logic        in_rdy, o_val, o_sof, o_eof, o_sol, o_eol, ovf_err;
  logic [71:0] o_data;
  logic        s_in_rdy, s_val, s_sof, s_eof, s_sol, s_eol, s_ovf;
  logic [71:0] s_data;

  always #5 clk = ~clk;

  window_3x3_1px dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .in_sol(in_sol), .in_eol(in_eol),
    .out3x3_val(o_val), .out3x3_rdy(out_rdy), .out3x3_data(o_data),
    .out3x3_sof(o_sof), .out3x3_eof(o_eof), .out3x3_sol(o_sol), .out3x3_eol(o_eol),
    .ovf_err(ovf_err)
  );

  window_3x3_1px #(.DATA_WIDTH(8), .MAX_LINE_WIDTH(8), .ADDR_WIDTH(3)) dut_s (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(s_in_rdy), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .in_sol(in_sol), .in_eol(in_eol),
    .out3x3_val(s_val), .out3x3_rdy(s_rdy), .out3x3_data(s_data),
    .out3x3_sof(s_sof), .out3x3_eof(s_eof), .out3x3_sol(s_sol), .out3x3_eol(s_eol),
    .ovf_err(s_ovf)
  );

  typedef struct packed {
    logic [71:0] data;
    logic sof, eof, sol, eol;
  } win_t;

  typedef struct {
    int w; int h; int pat; int mode; int gap; int exp_cnt;
  } vec_t;

  win_t       got_q[$], exp_q[$];
  logic [7:0] img [0:15][0:15];
  int         n_chk = 0, n_pass = 0;
  int         rdy_mode = 0, cyc = 0;
  int         s_cnt = 0;
  bit         s_eol_seen = 0;
  logic [7:0] s_ctr_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // downstream ready patterns: 0 always ready, 1 repeating 1-0-0-1, 2 random
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    case (rdy_mode)
      1:       out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       out_rdy = 1'($urandom_range(1));
      default: out_rdy = 1'b1;
    endcase
  end

  // main monitor: collects windows, checks hold-during-stall and backpressure
  initial begin
    logic [71:0] pd;
    logic [3:0]  pf;
    bit          pstall;
    pstall = 0; pd = '0; pf = '0;
    forever begin
      @(negedge clk);
      if (rst) pstall = 0;
      else begin
        if (pstall)
          chk("stall_hold", 128'({o_val, o_sof, o_eof, o_sol, o_eol, o_data}), 128'({1'b1, pf, pd}));
        if (o_val && !out_rdy) chk("in_rdy_stall", 128'(in_rdy), 128'(0));
        if (o_val && out_rdy) got_q.push_back('{o_data, o_sof, o_eof, o_sol, o_eol});
        pstall = o_val && !out_rdy;
        pd = o_data;
        pf = {o_sof, o_eof, o_sol, o_eol};
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && s_val) begin
      s_cnt++;
      s_ctr_q.push_back(s_data[39:32]);
      if (s_eol) s_eol_seen = 1;
    end
  end

  task automatic send_pix(input logic [7:0] d, input logic sof, eof, sol, eol);
    bit ok;
    ok = 0;
    in_val = 1'b1; in_data = d; in_sof = sof; in_eof = eof; in_sol = sol; in_eol = eol;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL handshake: in_rdy stayed 0 for 200 cycles");
    end
    in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_sol = 1'b0; in_eol = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int npix, input int gap);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (r * w + c < npix) begin
          if (gap != 0 && $urandom_range(2) == 0) begin @(posedge clk); #1; end
          send_pix(img[r][c], r == 0 && c == 0, r == h-1 && c == w-1, c == 0, c == w-1);
        end
  endtask

  task automatic fill(input int pat);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = (pat != 0) ? 8'($urandom) : 8'(10 * r + c);
  endtask

  // reference: every pixel at row>=2, col>=2 yields the 3x3 block ending at it
  task automatic build_exp(input int w, input int h, input int npix);
    win_t e;
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++)
        if (r * w + c < npix) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.data[(3*i+j)*8 +: 8] = img[r-2+i][c-2+j];
          e.sof = (r == 2 && c == 2);
          e.sol = (c == 2);
          e.eol = (c == w-1);
          e.eof = (r == h-1 && c == w-1);
          exp_q.push_back(e);
        end
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 4; i++) begin
      @(negedge clk);
      if (o_val) quiet = 0; else quiet++;
    end
    @(posedge clk); #1;
    if (quiet < 4) begin
      n_chk++;
      $display("FAIL drain: out3x3_val still active after 300 cycles");
    end
  endtask

  task automatic compare(input string name);
    int n;
    chk($sformatf("%s_count", name), 128'(got_q.size()), 128'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_win%0d", name, i), 128'(got_q[i]), 128'(exp_q[i]));
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{5, 4, 0, 0, 0, 6};
    tbl[1] = '{5, 4, 0, 1, 0, 6};
    tbl[2] = '{2, 5, 1, 0, 0, 0};
    tbl[3] = '{6, 2, 1, 0, 0, 0};
    tbl[4] = '{3, 3, 1, 1, 1, 1};
    tbl[5] = '{8, 6, 1, 2, 1, 24};
    tbl[6] = '{1, 1, 1, 0, 0, 0};
    tbl[7] = '{7, 5, 1, 2, 1, 15};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 128'({o_val, o_sof, o_eof, o_sol, o_eol, o_data, ovf_err}), 128'(0));
    chk("reset_outs_s", 128'({s_val, s_data, s_ovf}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      rdy_mode = tbl[v].mode;
      got_q.delete(); exp_q.delete();
      fill(tbl[v].pat);
      build_exp(tbl[v].w, tbl[v].h, tbl[v].w * tbl[v].h);
      send_frame(tbl[v].w, tbl[v].h, tbl[v].w * tbl[v].h, tbl[v].gap);
      drain();
      chk($sformatf("vec%0d_cnt", v), 128'(got_q.size()), 128'(tbl[v].exp_cnt));
      compare($sformatf("vec%0d", v));
      if (tbl[v].pat == 0 && got_q.size() >= 6) begin
        chk("s1_first_data", 128'(got_q[0].data), 128'(72'h16_15_14_0c_0b_0a_02_01_00));
        chk("s1_first_sofsol", 128'({got_q[0].sof, got_q[0].sol}), 128'(2'b11));
        chk("s1_third_eol_ctr", 128'({got_q[2].eol, got_q[2].data[39:32]}), 128'({1'b1, 8'd13}));
        chk("s1_last_eof_ctr", 128'({got_q[5].eof, got_q[5].data[39:32]}), 128'({1'b1, 8'd23}));
      end
    end

    for (int k = 0; k < 10; k++) begin
      int w, h;
      w = $urandom_range(9, 1);
      h = $urandom_range(7, 1);
      rdy_mode = $urandom_range(2);
      got_q.delete(); exp_q.delete();
      fill(1);
      build_exp(w, h, w * h);
      send_frame(w, h, w * h, $urandom_range(1));
      drain();
      compare($sformatf("rnd%0d", k));
    end

    // reset in the middle of row 3, then a stray non-sof pixel, then a clean frame
    rdy_mode = 0;
    fill(1);
    send_frame(5, 4, 16, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", 128'({o_val, o_sof, o_eof, o_sol, o_eol, o_data, ovf_err}), 128'(0));
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    send_pix(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    fill(0);
    build_exp(5, 4, 20);
    send_frame(5, 4, 20, 0);
    drain();
    compare("rst_recover");

    // sof reasserted at row 2, col 3 of an unfinished frame
    got_q.delete(); exp_q.delete();
    fill(1);
    build_exp(5, 4, 13);
    send_frame(5, 4, 13, 0);
    fill(0);
    build_exp(5, 4, 20);
    send_frame(5, 4, 20, 0);
    drain();
    compare("sof_restart");

    // 10-pixel lines into an 8-deep line buffer
    s_cnt = 0; s_ctr_q.delete(); s_eol_seen = 0;
    fill(0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 10; c++) begin
        send_pix(img[r][c], r == 0 && c == 0, r == 2 && c == 9, c == 0, c == 9);
        if (r == 0 && c == 7) chk("ovf_before", 128'(s_ovf), 128'(0));
        if (r == 0 && c == 8) chk("ovf_set", 128'(s_ovf), 128'(1));
      end
    drain();
    chk("ovf_sticky", 128'(s_ovf), 128'(1));
    chk("ovf_win_cnt", 128'(s_cnt), 128'(6));
    chk("ovf_no_eol", 128'(s_eol_seen), 128'(0));
    for (int i = 0; i < 6 && i < s_ctr_q.size(); i++)
      chk($sformatf("ovf_ctr%0d", i), 128'(s_ctr_q[i]), 128'(11 + i));
    s_cnt = 0;
    send_frame(3, 3, 1, 0);
    chk("ovf_clear_on_sof", 128'(s_ovf), 128'(0));
    send_frame(3, 3, 9, 0);
    drain();
    chk("ovf_next_frame_cnt", 128'(s_cnt), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/window_3x3_1px.md
Name: window_3x3_1px

Overview:
- Upstream neighbour of the 3x3 filter stages: the Laplace and sharpen filters.
- Converts a 1 pixel/cycle raster stream (val/rdy, sof/eof/sol/eol) into a 3x3 neighbourhood window per pixel on a 9*DATA_WIDTH bus that those stages consume.
- Uses two line buffers plus 3-column shift registers.
- Emits only fully-populated windows, so the output frame is (W-2)x(H-2).

Parameters:
- DATA_WIDTH, 8, bits per pixel
- MAX_LINE_WIDTH, 1024, maximum supported pixels per line; sets line-buffer depth
- ADDR_WIDTH, 10, column counter/RAM address width; must satisfy 2**ADDR_WIDTH >= MAX_LINE_WIDTH

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- in_val  in  1  upstream pixel valid
- in_rdy  out  1  this block can accept a pixel
- in_data  in  DATA_WIDTH  pixel
- in_sof  in  1  start of frame, first pixel
- in_eof  in  1  end of frame, last pixel
- in_sol  in  1  start of line
- in_eol  in  1  end of line
- out3x3_val  out  1  window valid
- out3x3_rdy  in  1  downstream ready
- out3x3_data  out  9*DATA_WIDTH  window; word k=3*row+col at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
  - row 0 = oldest line (top), col 0 = oldest column (left); centre is k=4
- out3x3_sof  out  1  first window of frame
- out3x3_eof  out  1  last window of frame
- out3x3_sol  out  1  first window of line
- out3x3_eol  out  1  last window of line
- ovf_err  out  1  sticky: a line exceeded MAX_LINE_WIDTH; cleared by rst or next in_sof

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst; all outputs are 0 at reset.
  - rst mid-frame discards all state; the next accepted pixel is ignored until an in_sof.
  - Line RAM contents are not reset.
- Handshake and pipeline:
  - Global enable en = ~out3x3_val | out3x3_rdy; in_rdy = en (combinational).
  - A pixel is accepted when in_val & in_rdy.
  - 2-stage pipe:
    - S1: RAM read at column address, col/row counters, input registered.
    - S2: window shift and output register.
  - Both stages advance only when en is high.
  - Latency from acceptance to out3x3_val is 2 cycles with out3x3_rdy held high.
  - out3x3_data and out3x3 flags hold stable while out3x3_val & ~out3x3_rdy.
  - Throughput is 1 window/cycle.
- Line buffers:
  - Two RAMs: LB0 holds line r-1, LB1 holds line r-2.
  - On an accepted pixel at column c: read both RAMs at c, write in_data to LB0[c], and write LB0 read data to LB1[c] in S1 (read-before-write).
- Counters:
  - col resets to 0 on in_sol, increments per accepted pixel, and saturates at MAX_LINE_WIDTH-1.
  - row resets on in_sof and increments after each in_eol.
  - in_sof implies sol and row=0, col=0; in_sof mid-frame restarts the frame and abandons the partial one.
  - in_eof without in_eol is treated as also eol.
  - A 1-pixel line with sof, sol, eol and eof all set is legal.
- Overflow:
  - When col would exceed MAX_LINE_WIDTH-1, RAM writes are suppressed and ovf_err is set.
  - No windows are emitted for the rest of that line.
- Output gating:
  - A window is emitted for the input pixel at (row, col) only if row>=2 and col>=2.
  - Centre pixel = (row-1, col-1).
  - out3x3_sof = row==2 & col==2.
  - out3x3_sol = col==2.
  - out3x3_eol = input eol.
  - out3x3_eof = input eof.
  - Lines shorter than 3 pixels and frames shorter than 3 lines produce no output.
- Arithmetic: none. Counters are ADDR_WIDTH wide (row uses 16 bits, saturating).

Optional Feature:
- Macro: WIN3X3_DIM_CHECK_EN.
- When defined:
  - Adds output port dim_err (1 bit) and latches the first line's width each frame.
  - dim_err pulses for one cycle when any later eol occurs at a different width.
  - Data flow is unaffected.
- When undefined: the port and logic are absent.

Decomposition:
- Package win3x3_pkg holds:
  - window word index constants: CTR=4, TL=0, BR=8
  - the 3-pixel minimum-dimension constant
  - the flag-bundle typedef {sof, eof, sol, eol}
- One sub-module: win3x3_line_ram, a simple dual-port RAM with registered read and read-enable, width DATA_WIDTH, depth MAX_LINE_WIDTH, instantiated twice.

Test Plan:
- Frame 5x4, pixel=10*r+c, out3x3_rdy=1:
  - 6 windows.
  - First window words 0..8 = 0,1,2,10,11,12,20,21,22 with sof=1 and sol=1.
  - Third window has eol=1, centre 13.
  - Last window centre 23 with eof=1.
- Same frame, out3x3_rdy toggling 1-0-0-1:
  - Identical window sequence; no loss or duplication.
  - Outputs stable during stalls; in_rdy=0 while out3x3_val & ~out3x3_rdy.
- Frame 2x5 (W=2) and 6x2 (H=2): out3x3_val never asserts.
- MAX_LINE_WIDTH=8, line of 10 pixels:
  - ovf_err=1 from pixel 9 until next in_sof.
  - No windows emitted for the rest of that line.
- rst asserted mid-frame (row 3): all outputs 0 the next cycle; the following clean 5x4 frame reproduces scenario 1 exactly.
- in_sof reasserted at row 2, col 3: no window with the old row count; the new frame's output matches scenario 1.
